// File: rtl/plru_update_pkg.sv
//------------------------------------------------------------------------------
// plru_update_pkg : shared types for the tree pseudo-LRU state keeper
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package plru_update_pkg;

    typedef enum logic [0:0] {
        ACC_TOUCH = 1'b0,
        ACC_INVAL = 1'b1
    } acc_kind_t;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } plru_state_t;

endpackage : plru_update_pkg

`default_nettype wire

// File: rtl/plru_path_update.sv
//------------------------------------------------------------------------------
// plru_path_update : combinational (bits, way, kind) -> new PLRU tree bits
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module plru_path_update
    import plru_update_pkg::*;
#(
    parameter int A_SIZE = 8
) (
    input  logic [A_SIZE-2:0]         i_bits,
    input  logic [$clog2(A_SIZE)-1:0] i_way,
    input  acc_kind_t                 i_kind,
    output logic [A_SIZE-2:0]         o_bits
);

    localparam int LEVELS = $clog2(A_SIZE);

    logic [A_SIZE-2:0] w_bits;
    logic [LEVELS-1:0] w_node;

    // The node at level i is (2^i - 1) plus the top i bits of the way index.
    always_comb begin
        w_bits = i_bits;
        w_node = '0;
        for (int i = 0; i < LEVELS; i++) begin
            w_node         = LEVELS'((1 << i) - 1) + (i_way >> (LEVELS - i));
            w_bits[w_node] = i_way[LEVELS-1-i] ^ (i_kind == ACC_INVAL);
        end
    end

    assign o_bits = w_bits;

endmodule : plru_path_update

`default_nettype wire

// File: rtl/plru_update.sv
//------------------------------------------------------------------------------
// plru_update : per-set PLRU bit store with two-stage read-modify-write update
// Optional macro PLRU_BYPASS_EN: forward stage-2 result to stage-1 same-set read
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module plru_update
    import plru_update_pkg::*;
#(
    parameter int A_SIZE   = 8,
    parameter int NUM_SETS = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_acc_valid,
    output logic                        o_acc_ready,
    input  logic [$clog2(NUM_SETS)-1:0] i_acc_set,
    input  logic [$clog2(A_SIZE)-1:0]   i_acc_way,
    input  acc_kind_t                   i_acc_kind,
    input  logic [$clog2(NUM_SETS)-1:0] i_rd_set,
    output logic [A_SIZE-2:0]           o_rd_bits,
    output logic                        o_init_done,
    output logic                        o_upd_done
);

    localparam int SETW = $clog2(NUM_SETS);
    localparam int WAYW = $clog2(A_SIZE);
    localparam int BW   = A_SIZE - 1;

    plru_state_t       r_state;
    logic [SETW-1:0]   r_init_cnt;
    logic              r_init_done;
    logic              r_s1_valid;
    logic [SETW-1:0]   r_s1_set;
    logic [WAYW-1:0]   r_s1_way;
    acc_kind_t         r_s1_kind;
    logic [BW-1:0]     r_s1_bits;
    logic [BW-1:0]     r_rd_bits;
    logic [BW-1:0]     r_mem [NUM_SETS];

    logic [BW-1:0]     w_new_bits;
    logic              w_we;
    logic [SETW-1:0]   w_waddr;
    logic [BW-1:0]     w_wdata;
    logic              w_same_set;
    logic              w_hazard;
    logic [BW-1:0]     w_s1_rd;
    logic              w_accept;

    plru_path_update #(
        .A_SIZE (A_SIZE)
    ) u_path (
        .i_bits (r_s1_bits),
        .i_way  (r_s1_way),
        .i_kind (r_s1_kind),
        .o_bits (w_new_bits)
    );

    // Single write port shared by the clear sweep and the stage-2 commit.
    assign w_we       = (r_state == S_INIT) || r_s1_valid;
    assign w_waddr    = (r_state == S_INIT) ? r_init_cnt : r_s1_set;
    assign w_wdata    = (r_state == S_INIT) ? '0 : w_new_bits;
    assign w_same_set = r_s1_valid && (r_s1_set == i_acc_set);

`ifdef PLRU_BYPASS_EN
    assign w_hazard = 1'b0;
    assign w_s1_rd  = w_same_set ? w_new_bits : r_mem[i_acc_set];
`else
    assign w_hazard = w_same_set;
    assign w_s1_rd  = r_mem[i_acc_set];
`endif

    assign o_acc_ready = r_init_done && !w_hazard;
    assign w_accept    = i_acc_valid && o_acc_ready;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_set    <= '0;
            r_s1_way    <= '0;
            r_s1_kind   <= ACC_TOUCH;
            r_s1_bits   <= '0;
            r_rd_bits   <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == SETW'(NUM_SETS - 1)) begin
                        r_state     <= S_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_state <= S_RUN;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase

            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_set  <= i_acc_set;
                r_s1_way  <= i_acc_way;
                r_s1_kind <= i_acc_kind;
                r_s1_bits <= w_s1_rd;
            end

            r_rd_bits <= (w_we && (w_waddr == i_rd_set)) ? w_wdata : r_mem[i_rd_set];
        end
    end

    assign o_rd_bits   = r_rd_bits;
    assign o_init_done = r_init_done;
    assign o_upd_done  = r_s1_valid;

endmodule : plru_update

`default_nettype wire

// File: tb/tb_plru_update.sv
//------------------------------------------------------------------------------
// tb_plru_update : directed stimulus with a range-walking PLRU reference model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_plru_update;
    import plru_update_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       acc_valid = 1'b0;
    logic       acc_ready;
    logic [5:0] acc_set = '0;
    logic [2:0] acc_way = '0;
    acc_kind_t  acc_kind = ACC_TOUCH;
    logic [5:0] rd_set = '0;
    logic [6:0] rd_bits;
    logic       init_done;
    logic       upd_done;

    int n_checks = 0;
    int n_pass   = 0;

    plru_update #(.A_SIZE(8), .NUM_SETS(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_acc_valid (acc_valid),
        .o_acc_ready (acc_ready),
        .i_acc_set   (acc_set),
        .i_acc_way   (acc_way),
        .i_acc_kind  (acc_kind),
        .i_rd_set    (rd_set),
        .o_rd_bits   (rd_bits),
        .o_init_done (init_done),
        .o_upd_done  (upd_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: walk the way range by halves from the root.
    function automatic logic [6:0] apply(input logic [6:0] b, input int way, input bit inval);
        logic [6:0] r = b;
        int lo = 0, hi = 8, n = 0, mid;
        bit right;
        while (hi - lo > 1) begin
            mid   = (lo + hi) / 2;
            right = (way >= mid);
            r[n]  = inval ? !right : right;
            if (right) begin lo = mid; n = 2 * n + 2; end
            else       begin hi = mid; n = 2 * n + 1; end
        end
        return r;
    endfunction

    function automatic int victim(input logic [6:0] b);
        int lo = 0, hi = 8, n = 0, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (b[n]) begin hi = mid; n = 2 * n + 1; end
            else      begin lo = mid; n = 2 * n + 2; end
        end
        return lo;
    endfunction

    // Cycle-level compare process.
    logic [6:0] model [64];
    bit model_ok = 0;
    bit p1_v = 0, p2_v = 0, p1_inv = 0, p2_inv = 0;
    int p1_set = 0, p2_set = 0, p1_way = 0, p2_way = 0, rd_prev = 0;
    bit exp_ready;

    always @(negedge clk) begin
        if (!rst_n) begin
            model_ok = 0;
            p1_v = 0;
            p2_v = 0;
        end else begin
            if (!model_ok && init_done) begin
                for (int i = 0; i < 64; i++) model[i] = '0;
                model_ok = 1;
            end
            if (model_ok) begin
                if (p2_v) model[p2_set] = apply(model[p2_set], p2_way, p2_inv);
`ifdef PLRU_BYPASS_EN
                exp_ready = 1'b1;
`else
                exp_ready = !(p1_v && (p1_set == int'(acc_set)));
`endif
                chk("mon_rd_bits", 32'(rd_bits), 32'(model[rd_prev]));
                chk("mon_upd_done", 32'(upd_done), 32'(p1_v));
                chk("mon_init_done", 32'(init_done), 32'd1);
                chk("mon_acc_ready", 32'(acc_ready), 32'(exp_ready));
            end
            p2_v = p1_v; p2_set = p1_set; p2_way = p1_way; p2_inv = p1_inv;
            p1_v   = acc_valid && acc_ready;
            p1_set = int'(acc_set);
            p1_way = int'(acc_way);
            p1_inv = (acc_kind == ACC_INVAL);
            rd_prev = int'(rd_set);
        end
    end

    // Called at posedge+1; returns at posedge+1 just after acceptance, valid left high.
    task automatic issue(input int s, input int w, input acc_kind_t k, output int stalls);
        bit ok = 0;
        acc_valid = 1'b1;
        acc_set   = 6'(s);
        acc_way   = 3'(w);
        acc_kind  = k;
        stalls    = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (acc_ready) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        chk("accept_in_bound", 32'(ok), 32'd1);
    endtask

    task automatic idle(input int n);
        acc_valid = 1'b0;
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic release_and_count(input string name);
        int cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (acc_ready) break;
        end
        chk(name, 32'(cnt), 32'd64);
        chk({name, "_init_done"}, 32'(init_done), 32'd1);
    endtask

    task automatic read_lit(input string name, input int s, input logic [6:0] exp);
        rd_set = 6'(s);
        @(posedge clk); #1;
        chk(name, 32'(rd_bits), 32'(exp));
    endtask

    initial begin
        int st, cnt;

        repeat (3) @(negedge clk);
        chk("rst_acc_ready", 32'(acc_ready), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_upd_done", 32'(upd_done), 32'd0);
        chk("rst_rd_bits", 32'(rd_bits), 32'd0);
        release_and_count("init_cycles");

        for (int s = 0; s < 64; s += 7) begin rd_set = 6'(s); @(posedge clk); #1; end
        read_lit("clear_set5", 5, 7'h00);

        issue(5, 7, ACC_TOUCH, st); idle(2);
        read_lit("touch7_set5", 5, 7'h45);
        chk("victim_set5", 32'(victim(rd_bits)), 32'd3);

        issue(6, 0, ACC_INVAL, st); idle(2);
        read_lit("inval0_set6", 6, 7'h0B);
        issue(7, 0, ACC_TOUCH, st); idle(2);
        read_lit("touch0_set7", 7, 7'h00);

        issue(2, 7, ACC_TOUCH, st);
        issue(2, 0, ACC_TOUCH, st);
`ifdef PLRU_BYPASS_EN
        chk("b2b_stalls", 32'(st), 32'd0);
`else
        chk("b2b_stalls", 32'(st), 32'd1);
`endif
        idle(2);
        read_lit("b2b_set2", 2, 7'h44);

        rd_set = 6'd9;
        idle(2);
        issue(9, 7, ACC_TOUCH, st);
        chk("wt_before", 32'(rd_bits), 32'd0);
        acc_valid = 1'b0;
        cnt = 0;
        @(negedge clk); cnt += int'(upd_done);
        @(posedge clk); #1;
        chk("wt_commit", 32'(rd_bits), 32'h45);
        @(negedge clk); cnt += int'(upd_done);
        @(negedge clk); cnt += int'(upd_done);
        chk("upd_pulses", 32'(cnt), 32'd1);

        @(posedge clk); #1;
        issue(3, 7, ACC_TOUCH, st);
        acc_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_upd_done", 32'(upd_done), 32'd0);
        chk("midrst_init_done", 32'(init_done), 32'd0);
        chk("midrst_acc_ready", 32'(acc_ready), 32'd0);
        @(negedge clk);
        release_and_count("reinit_cycles");
        for (int s = 0; s < 64; s++) begin rd_set = 6'(s); @(posedge clk); #1; end
        read_lit("reinit_set3", 3, 7'h00);
        read_lit("reinit_set5", 5, 7'h00);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule : tb_plru_update

`default_nettype wire

// File: doc/plru_update.md
# plru_update

Tree pseudo-LRU state keeper and updater for the set-associative cache. It stores the a_size-1 PLRU tree bits per set and applies touch (hit/fill) and invalidate (snoop/evict) events through a two-stage read-modify-write pipeline. It also serves registered reads of a set's bits to the eviction LRU victim selector. It uses the same tree encoding the selector walks: node 0 is the root, children of node a are 2a+1 (left) and 2a+2 (right), and a node bit of 1 means the victim lies in the left half.

## Interface
- a_size, 8: ways per set; power of 2, at least 2.
- num_sets, 64: sets; power of 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- acc_valid  in  1  access event offered.
- acc_ready  out  1  event accepted on a clk edge when acc_valid && acc_ready.
- acc_set  in  $clog2(num_sets)  set index.
- acc_way  in  $clog2(a_size)  way accessed.
- acc_kind  in  acc_kind_t (1)  ACC_TOUCH = make the way MRU; ACC_INVAL = make the way LRU.
- rd_set  in  $clog2(num_sets)  read index for the victim selector.
- rd_bits  out  a_size-1  PLRU bits of rd_set, registered.
- init_done  out  1  high once the post-reset clear sweep has finished.
- upd_done  out  1  one-cycle pulse when a stage-2 write commits.

## Operation
- FSM states:
  - S_INIT: a counter walks sets 0..num_sets-1 and writes zeros, one set per cycle.
  - After set num_sets-1 is written, the next state is S_RUN and init_done goes to 1.
  - S_RUN persists until reset.
- acc_ready is 0 in S_INIT. In S_RUN it is 1 except for the hazard stall described under Configuration.
- Stage 1, on acceptance: registers set, way and kind, and reads the array entry for that set.
- Stage 2, the next cycle: computes the new bits and writes them back. upd_done pulses for that cycle.
- Path update: for level i (0 = root), d = acc_way bit [log2(a_size)-1-i] and node n starts at 0.
  - ACC_TOUCH sets bit n = d. ACC_INVAL sets bit n = ~d.
  - Then n = 2n+1 if d = 0, else n = 2n+2.
  - Exactly log2(a_size) bits change; all other bits are unchanged.
- Read port: rd_bits is array[rd_set] sampled at the edge, with write-through. If stage 2 writes rd_set at that same edge, rd_bits shows the new value.
- Back-to-back accesses to different sets are accepted every cycle, giving full throughput.
- Reset mid-operation: all pipeline valids clear, any in-flight update is dropped, and the FSM returns to S_INIT with the counter at 0.
- Reset values of outputs: acc_ready 0, rd_bits 0, init_done 0, upd_done 0.

## Timing
- Acceptance at edge T → array written at edge T+1 → visible on rd_bits from the edge T+1 sample.
- rd_bits latency is 1 cycle from rd_set.
- The init sweep takes num_sets cycles after rst_n deasserts. init_done and acc_ready rise together on the first S_RUN cycle.
- Events are never dropped while in S_RUN. acc_* must be held stable while acc_valid && !acc_ready.

## Configuration
- PLRU_BYPASS_EN defined:
  - A stage-1 read of the set currently being written by stage 2 takes stage 2's new bits, not the array value.
  - Same-set back-to-back events are accepted every cycle, and the effects of both accumulate.
- PLRU_BYPASS_EN undefined:
  - acc_ready is forced low for one cycle when acc_set equals the stage-1 set while stage 1 is valid.
  - The second event is then accepted one cycle later and reads the committed value.
  - Final array contents are identical in both builds; only throughput differs.

## Structure
- mypkg gains:
  - acc_kind_t (ACC_TOUCH = 0, ACC_INVAL = 1).
  - plru_state_t (S_INIT, S_RUN).
- One combinational sub-module, plru_path_update, maps (bits, way, kind) to new bits. The victim selector's testbench reuses it as a reference model.

## Test plan
- Reset, then wait: acc_ready = 0 for exactly 64 cycles, then init_done = acc_ready = 1. Reading any set gives 7'h00.
- a_size = 8, set 5 cleared; TOUCH way 7 → rd_bits(5) = 7'h45, and the victim selector on those bits yields way 3.
- Set 5 cleared; INVAL way 0 → 7'h0B. TOUCH way 0 from 7'h00 → 7'h00 (unchanged).
- Same-set back-to-back: TOUCH way 7 then TOUCH way 0 on set 2.
  - Result is 7'h44 in both builds.
  - With PLRU_BYPASS_EN, acc_ready stays 1.
  - Without it, acc_ready = 0 for one cycle.
- rd_set = 9 held while TOUCH way 7 commits to set 9: rd_bits reads 7'h00 before the commit and 7'h45 in the commit-edge sample. upd_done pulses once.
- rst_n asserted while an update is in stage 2: the write is lost, the FSM re-enters S_INIT, the sweep restarts from set 0, and after init all sets read 7'h00.
